// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter that shares the single LCD character-write port between two requesters.
// It holds the granted byte stable, sequences the write/ready handshake, and runs a sticky watchdog.
module lcd_write_arbiter #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iInitialized,
    input  logic              iReq0,
    input  logic [DATA_W-1:0] iData0,
    output logic              oAck0,
    input  logic              iReq1,
    input  logic [DATA_W-1:0] iData1,
    output logic              oAck1,
    output logic              oLcdWrite,
    output logic [DATA_W-1:0] oLcdData,
    input  logic              iLcdReady,
    output logic              oBusy,
    output logic              oLastGrant,
    output logic              oTimeout
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ptr_q, ptr_d;
    logic              last_grant_q, last_grant_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic              winner;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            data_q       <= '0;
            ptr_q        <= 1'b1;
            last_grant_q <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            data_q       <= data_d;
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        data_d       = data_q;
        ptr_d        = ptr_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        write_d      = 1'b0;
        timeout_d    = timeout_q;
        winner       = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (iInitialized && (iReq0 || iReq1)) begin
                    // On a tie the port that was not granted last wins.
                    winner       = (iReq0 && iReq1) ? ~ptr_q : iReq1;
                    data_d       = winner ? iData1 : iData0;
                    ack0_d       = ~winner;
                    ack1_d       = winner;
                    ptr_d        = winner;
                    last_grant_d = winner;
                    write_d      = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!iLcdReady) begin
                    timer_d = '0;
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_ERROR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (iLcdReady) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_ERROR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_ERROR: begin
                timeout_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Losing init aborts any transfer in flight; only the error state ignores it.
        if (!iInitialized && (state_q != S_ERROR)) begin
            state_d = S_IDLE;
            timer_d = '0;
            write_d = 1'b0;
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign oAck0      = ack0_q;
    assign oAck1      = ack1_q;
    assign oLcdWrite  = write_q;
    assign oLcdData   = data_q;
    assign oBusy      = busy_q;
    assign oLastGrant = last_grant_q;
    assign oTimeout   = timeout_q;

endmodule
